// File: rtl/ysyx_24100013_pkg.sv
// Shared types and constants for the ysyx_24100013 multi-cycle sequencer:
// FSM state encoding, immediate-type selects, RV32I opcodes, halt codes.
package ysyx_24100013_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WB         = 3'd6,
    HALT       = 3'd7
  } state_e;

  localparam logic [2:0] ITYPE_NONE = 3'd0;
  localparam logic [2:0] ITYPE_I    = 3'd1;
  localparam logic [2:0] ITYPE_S    = 3'd2;
  localparam logic [2:0] ITYPE_B    = 3'd3;
  localparam logic [2:0] ITYPE_U    = 3'd4;
  localparam logic [2:0] ITYPE_J    = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

endpackage

// File: rtl/ysyx_24100013_opdec.sv
// Combinational opcode decoder: immediate-type select plus the load/store,
// rd-write and illegal-opcode classification used by the sequencer.
module ysyx_24100013_opdec
  import ysyx_24100013_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] itype,
  output logic       is_load,
  output logic       is_store,
  output logic       writes_rd,
  output logic       illegal
);

  // Classify the opcode; anything outside RV32I base is flagged illegal.
  always_comb begin
    itype     = ITYPE_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        itype     = ITYPE_U;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        itype     = ITYPE_J;
        writes_rd = 1'b1;
      end
      OPC_JALR, OPC_OPIMM, OPC_SYSTEM: begin
        itype     = ITYPE_I;
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        itype     = ITYPE_I;
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        itype     = ITYPE_S;
        is_store  = 1'b1;
      end
      OPC_BRANCH: begin
        itype     = ITYPE_B;
      end
      OPC_OP: begin
        itype     = ITYPE_NONE;
        writes_rd = 1'b1;
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24100013_seq.sv
// Multi-cycle NPC sequencer: fetch/data handshakes, instruction latch,
// itype decode, one-cycle PC/RF retire strobes and sticky halt.
// Optional memory-wait timeout enabled by YSYX_24100013_SEQ_TIMEOUT_EN.
module ysyx_24100013_seq
  import ysyx_24100013_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  output logic [2:0]  itype,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic [1:0]  halt_code
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [2:0]  itype_q, itype_d;
  logic [1:0]  halt_code_q, halt_code_d;
  logic        halt_q, halt_d;
  logic        ifu_req_valid_q, ifu_req_valid_d;
  logic        lsu_req_valid_q, lsu_req_valid_d;
  logic        lsu_req_wen_q, lsu_req_wen_d;
  logic        rf_we_q, rf_we_d;
  logic        pc_we_q, pc_we_d;

  logic [2:0]  dec_itype;
  logic        dec_is_load, dec_is_store, dec_writes_rd, dec_illegal;
  logic        ifu_accept, lsu_accept, tmo_hit;

  ysyx_24100013_opdec u_opdec (
    .opcode    (inst_q[6:0]),
    .itype     (dec_itype),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .writes_rd (dec_writes_rd),
    .illegal   (dec_illegal)
  );

  // A request only completes once its registered valid is actually visible.
  assign ifu_accept = ifu_req_valid_q & ifu_req_ready;
  assign lsu_accept = lsu_req_valid_q & lsu_req_ready;

`ifdef YSYX_24100013_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Hit on the last permitted wait cycle so the HALT transition lands after
  // exactly TIMEOUT_CYCLES cycles spent waiting.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: clears when a new request phase starts, counts while waiting.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (((state_d == FETCH_REQ) && (state_q != FETCH_REQ)) ||
        ((state_d == MEM_REQ) && (state_q != MEM_REQ))) begin
      tmo_cnt_d = '0;
    end else if ((state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                 (state_q == MEM_REQ) || (state_q == MEM_WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // No counter in this build: waits are unbounded, the parameter is inert.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic plus the inst/itype/halt-code updates tied to transitions.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    itype_d     = itype_q;
    halt_code_d = halt_code_q;
    case (state_q)
      FETCH_REQ: begin
        if (ifu_accept) begin
          state_d = FETCH_WAIT;
        end else if (tmo_hit) begin
          state_d     = HALT;
          halt_code_d = HALT_TIMEOUT;
        end else begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = DECODE;
        end else if (tmo_hit) begin
          state_d     = HALT;
          halt_code_d = HALT_TIMEOUT;
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      DECODE: begin
        itype_d = dec_itype;
        if (inst_q == INST_EBREAK) begin
          state_d     = HALT;
          halt_code_d = HALT_EBREAK;
        end else if (dec_illegal) begin
          state_d     = HALT;
          halt_code_d = HALT_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_is_load || dec_is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        if (lsu_accept) begin
          state_d = MEM_WAIT;
        end else if (tmo_hit) begin
          state_d     = HALT;
          halt_code_d = HALT_TIMEOUT;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = WB;
        end else if (tmo_hit) begin
          state_d     = HALT;
          halt_code_d = HALT_TIMEOUT;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      WB: begin
        state_d = FETCH_REQ;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // Output flops are loaded from the upcoming state so they align with it.
  always_comb begin
    ifu_req_valid_d = (state_d == FETCH_REQ);
    lsu_req_valid_d = (state_d == MEM_REQ);
    lsu_req_wen_d   = (state_d == MEM_REQ) & dec_is_store;
    pc_we_d         = (state_d == WB);
    rf_we_d         = (state_d == WB) & dec_writes_rd & (inst_q[11:7] != 5'd0);
    halt_d          = (state_d == HALT);
  end

  // State, instruction latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH_REQ;
      inst_q          <= 32'd0;
      itype_q         <= ITYPE_NONE;
      halt_q          <= 1'b0;
      halt_code_q     <= HALT_NONE;
      ifu_req_valid_q <= 1'b0;
      lsu_req_valid_q <= 1'b0;
      lsu_req_wen_q   <= 1'b0;
      rf_we_q         <= 1'b0;
      pc_we_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      inst_q          <= inst_d;
      itype_q         <= itype_d;
      halt_q          <= halt_d;
      halt_code_q     <= halt_code_d;
      ifu_req_valid_q <= ifu_req_valid_d;
      lsu_req_valid_q <= lsu_req_valid_d;
      lsu_req_wen_q   <= lsu_req_wen_d;
      rf_we_q         <= rf_we_d;
      pc_we_q         <= pc_we_d;
    end
  end

  assign ifu_req_valid = ifu_req_valid_q;
  assign lsu_req_valid = lsu_req_valid_q;
  assign lsu_req_wen   = lsu_req_wen_q;
  assign inst          = inst_q;
  assign itype         = itype_q;
  assign rf_we         = rf_we_q;
  assign pc_we         = pc_we_q;
  assign halt          = halt_q;
  assign halt_code     = halt_code_q;

endmodule

// File: tb/tb_ysyx_24100013_seq.sv
// Self-checking bench for ysyx_24100013_seq: acts as instruction and data
// memory with randomized handshake delays, predicts itype / strobes / halt
// from an opcode table. Inputs driven and outputs sampled on negedge.
module tb_ysyx_24100013_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_data = 32'd0;
  logic [31:0] inst;
  logic [2:0]  itype;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        rf_we, pc_we, halt;
  logic [1:0]  halt_code;

  int vectors = 0;
  int errors  = 0;
  int pc_cnt  = 0;
  int rf_cnt  = 0;

  // Reference opcode table: RV32I base opcodes and their immediate select.
  logic [6:0] op_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
  logic [2:0] it_tab [10] = '{3'd4, 3'd4, 3'd5, 3'd1, 3'd3, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1};

  ysyx_24100013_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .inst(inst), .itype(itype),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    if (pc_we === 1'b1) pc_cnt++;
    if (rf_we === 1'b1) rf_cnt++;
  endtask

  function automatic int op_index(input logic [31:0] ins);
    for (int k = 0; k < 10; k++) if (op_tab[k] == ins[6:0]) return k;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  // One instruction through the core with given ready/response delays.
  task automatic run_inst(input logic [31:0] ins, input int d_rq, input int d_rs,
                          input int d_mq, input int d_mp, output bit halted);
    int idx, n, p0, r0;
    bit legal, ebrk, mem, st, wr;
    logic [2:0] exp_it;
    idx    = op_index(ins);
    legal  = (idx >= 0);
    ebrk   = (ins == 32'h00100073);
    exp_it = legal ? it_tab[idx] : 3'd0;
    mem    = legal && (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011);
    st     = legal && (ins[6:0] == 7'b0100011);
    wr     = legal && !(ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1100011) && (ins[11:7] != 5'd0);
    halted = 1'b1;
    n = 0;
    while (ifu_req_valid !== 1'b1 && n < 4) begin cyc(); n++; end
    vectors++;
    if (ifu_req_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_req: ifu_req_valid=%b required 1", ifu_req_valid); return;
    end
    p0 = pc_cnt; r0 = rf_cnt;
    repeat (d_rq) begin
      cyc(); vectors++;
      if (ifu_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_hold: valid=%b required 1", ifu_req_valid); end
    end
    ifu_req_ready = 1'b1; cyc(); ifu_req_ready = 1'b0;
    vectors++;
    if (ifu_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_drop: valid=%b required 0", ifu_req_valid); end
    repeat (d_rs) cyc();
    ifu_rsp_valid = 1'b1; ifu_rsp_data = ins; cyc();
    ifu_rsp_valid = 1'b0; ifu_rsp_data = $urandom;
    cyc();
    vectors++;
    if (inst !== ins || itype !== exp_it) begin
      errors++; $display("FAIL decode: inst=%h itype=%0d required inst=%h itype=%0d", inst, itype, ins, exp_it);
    end
    if (!legal || ebrk) begin
      vectors++;
      if (halt !== 1'b1 || halt_code !== (ebrk ? 2'd1 : 2'd2) || pc_cnt != p0 || rf_cnt != r0) begin
        errors++; $display("FAIL halt_entry: halt=%b code=%0d pc_we_count=%0d required halt=1 code=%0d pc_we_count=0",
                           halt, halt_code, pc_cnt - p0, ebrk ? 1 : 2);
      end
      return;
    end
    vectors++;
    if (halt !== 1'b0) begin errors++; $display("FAIL no_halt: halt=%b required 0", halt); end
    if (mem) begin
      cyc();
      vectors++;
      if (lsu_req_valid !== 1'b1 || lsu_req_wen !== st) begin
        errors++; $display("FAIL mem_req: valid=%b wen=%b required 1 %b", lsu_req_valid, lsu_req_wen, st);
      end
      repeat (d_mq) begin
        ifu_rsp_valid = 1'($urandom_range(0, 1)); cyc(); ifu_rsp_valid = 1'b0;
        vectors++;
        if (lsu_req_valid !== 1'b1 || lsu_req_wen !== st) begin
          errors++; $display("FAIL mem_hold: valid=%b wen=%b required 1 %b", lsu_req_valid, lsu_req_wen, st);
        end
      end
      lsu_req_ready = 1'b1; cyc(); lsu_req_ready = 1'b0;
      vectors++;
      if (lsu_req_valid !== 1'b0) begin errors++; $display("FAIL mem_drop: valid=%b required 0", lsu_req_valid); end
      repeat (d_mp) begin ifu_rsp_valid = 1'($urandom_range(0, 1)); cyc(); ifu_rsp_valid = 1'b0; end
      lsu_rsp_valid = 1'b1; cyc(); lsu_rsp_valid = 1'b0;
    end else begin
      cyc();
    end
    vectors++;
    if (pc_we !== 1'b1 || rf_we !== wr || pc_cnt - p0 != 1 || rf_cnt - r0 != int'(wr)) begin
      errors++; $display("FAIL wb_strobe: pc_we=%b rf_we=%b counts=%0d/%0d required 1 %b counts=1/%0d",
                         pc_we, rf_we, pc_cnt - p0, rf_cnt - r0, wr, wr);
    end
    vectors++;
    if (inst !== ins || itype !== exp_it) begin
      errors++; $display("FAIL wb_stable: inst=%h itype=%0d required %h %0d", inst, itype, ins, exp_it);
    end
    cyc();
    vectors++;
    if (pc_we !== 1'b0 || rf_we !== 1'b0 || ifu_req_valid !== 1'b1) begin
      errors++; $display("FAIL after_wb: pc_we=%b rf_we=%b ifu_req_valid=%b required 0 0 1", pc_we, rf_we, ifu_req_valid);
    end
    halted = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hdeadbeef;
    lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
    cyc(); cyc();
    vectors++;
    if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 || lsu_req_wen !== 1'b0 || rf_we !== 1'b0 ||
        pc_we !== 1'b0 || halt !== 1'b0 || halt_code !== 2'd0 || inst !== 32'd0 || itype !== 3'd0) begin
      errors++; $display("FAIL reset_state: valids=%b%b strobes=%b%b halt=%b code=%0d inst=%h itype=%0d required all 0",
                         ifu_req_valid, lsu_req_valid, rf_we, pc_we, halt, halt_code, inst, itype);
    end
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    rst = 1'b0;
    cyc();
    vectors++;
    if (ifu_req_valid !== 1'b1) begin errors++; $display("FAIL reset_fetch: ifu_req_valid=%b required 1", ifu_req_valid); end
  endtask

  task automatic test_directed();
    bit h;
    run_inst(32'h00500093, 0, 0, 0, 0, h);   // ADDI x1,x0,5
    run_inst(32'h00112023, 0, 0, 3, 0, h);   // SW x1,0(x2)
    run_inst(32'h00000013, 1, 2, 0, 0, h);   // ADDI x0,x0,0
    run_inst(32'h0000a083, 0, 1, 1, 2, h);   // LW x1,0(x1)
  endtask

  task automatic test_random();
    bit h;
    logic [31:0] r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      run_inst({r[31:7], op_tab[$urandom_range(0, 9)]}, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), h);
      if (h) do_reset();
    end
  endtask

  task automatic test_ebreak();
    bit h;
    run_inst(32'h00100073, 0, 0, 0, 0, h);
    for (int i = 0; i < 6; i++) begin
      ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'h00500093; lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
      cyc();
      vectors++;
      if (halt !== 1'b1 || halt_code !== 2'd1 || ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 ||
          pc_we !== 1'b0 || rf_we !== 1'b0 || inst !== 32'h00100073 || itype !== 3'd1) begin
        errors++; $display("FAIL halt_sticky: halt=%b code=%0d valids=%b%b strobes=%b%b inst=%h required 1 1 00 00 00100073",
                           halt, halt_code, ifu_req_valid, lsu_req_valid, pc_we, rf_we, inst);
      end
    end
    do_reset();
  endtask

  task automatic test_illegal();
    bit h;
    logic [31:0] r;
    logic [6:0] op;
    r = $urandom;
    run_inst({r[31:7], 7'b1111111}, 0, 0, 0, 0, h);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      op = r[6:0];
      while (op_index({25'd0, op}) >= 0) op = op + 7'd1;
      run_inst({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, h);
      do_reset();
    end
  endtask

  task automatic test_reset_mid();
    bit h;
    ifu_req_ready = 1'b1; cyc(); ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'h0000a083; cyc(); ifu_rsp_valid = 1'b0;
    cyc(); cyc();
    lsu_req_ready = 1'b1; cyc(); lsu_req_ready = 1'b0;   // now waiting for the load data
    rst = 1'b1; cyc();
    vectors++;
    if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0 ||
        halt !== 1'b0 || halt_code !== 2'd0 || inst !== 32'd0 || itype !== 3'd0) begin
      errors++; $display("FAIL mid_reset: valids=%b%b strobes=%b%b halt=%b inst=%h itype=%0d required all 0",
                         ifu_req_valid, lsu_req_valid, rf_we, pc_we, halt, inst, itype);
    end
    rst = 1'b0; lsu_rsp_valid = 1'b1; cyc(); lsu_rsp_valid = 1'b0;
    vectors++;
    if (ifu_req_valid !== 1'b1 || pc_we !== 1'b0 || rf_we !== 1'b0 || lsu_req_valid !== 1'b0) begin
      errors++; $display("FAIL late_rsp: ifu_req_valid=%b pc_we=%b rf_we=%b lsu_req_valid=%b required 1 0 0 0",
                         ifu_req_valid, pc_we, rf_we, lsu_req_valid);
    end
    run_inst(32'h00700113, 0, 0, 0, 0, h);   // ADDI x2,x0,7
  endtask

  task automatic test_timeout();
    ifu_req_ready = 1'b1; cyc(); ifu_req_ready = 1'b0;
    repeat (20) cyc();
    vectors++;
`ifdef YSYX_24100013_SEQ_TIMEOUT_EN
    if (halt !== 1'b1 || halt_code !== 2'd3) begin
      errors++; $display("FAIL timeout: halt=%b code=%0d required 1 3", halt, halt_code);
    end
`else
    if (halt !== 1'b0 || halt_code !== 2'd0 || ifu_req_valid !== 1'b0) begin
      errors++; $display("FAIL no_timeout: halt=%b code=%0d ifu_req_valid=%b required 0 0 0", halt, halt_code, ifu_req_valid);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ebreak();
    test_illegal();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24100013_seq.md
# ysyx_24100013_seq

Multi-cycle core sequencer for the NPC. Issues instruction fetches and data-memory requests over valid/ready handshakes and latches the fetched instruction. Decodes the opcode into the immediate-type select consumed by the immediate generator. Generates the one-cycle PC and register-file write strobes that retire each instruction, and halts on `ebreak`, an illegal opcode or an optional memory timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1024: max cycles waiting on any memory response; used only with the timeout feature.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  out  1  fetch request; address is the external PC.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_data  in  32  fetched instruction.
- inst  out  32  latched current instruction.
- itype  out  3  immediate select: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
- lsu_req_valid  out  1  data-memory request.
- lsu_req_wen  out  1  1 = store, 0 = load; valid only with lsu_req_valid.
- lsu_req_ready  in  1  data request accepted.
- lsu_rsp_valid  in  1  load data / store acknowledge.
- rf_we  out  1  register-file write strobe, one cycle.
- pc_we  out  1  PC update strobe, one cycle.
- halt  out  1  sticky halt.
- halt_code  out  2  0 none, 1 ebreak, 2 illegal, 3 timeout.

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset: state FETCH_REQ; inst=0, itype=0, halt=0, halt_code=0; all valids and strobes 0.
- FETCH_REQ:
  - ifu_req_valid=1, held until ifu_req_ready.
  - On accept, go to FETCH_WAIT.
- FETCH_WAIT:
  - On ifu_rsp_valid, latch inst and go to DECODE.
  - A response never arrives in the accepting cycle.
  - ifu_rsp_valid in any other state is ignored.
- DECODE:
  - Register itype from inst[6:0]:
    - LUI/AUIPC → 4.
    - JAL → 5.
    - JALR/LOAD/OP-IMM/SYSTEM → 1.
    - STORE → 2.
    - BRANCH → 3.
    - OP → 0.
  - Any other opcode → HALT, halt_code=2.
  - inst == 32'h00100073 → HALT, halt_code=1.
- EXEC:
  - LOAD/STORE → MEM_REQ.
  - Otherwise → WB.
- MEM_REQ:
  - lsu_req_valid=1, with lsu_req_wen=1 for STORE.
  - Held until lsu_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid, go to WB.
- WB:
  - pc_we=1.
  - rf_we=1 unless opcode is STORE or BRANCH, or rd (inst[11:7]) == 0.
  - Then go to FETCH_REQ.
- HALT:
  - Absorbing; all valids and strobes 0; halt=1; inst and itype hold.
  - Left only by rst.
- rst asserted in any state, including mid-handshake, returns to the reset state next edge.
  - Outstanding responses arriving after reset are ignored until the next request is accepted.
- itype and inst are stable from DECODE+1 through WB.

## Timing
- Non-memory instruction, zero-wait memory: 5 cycles (FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB).
- Load/store: 7 cycles minimum.
- Each wait cycle on a ready or response adds one cycle.
- Strobes are registered outputs; rf_we and pc_we are high exactly one cycle per retired instruction.
- Valid must not deassert before its ready. Address and wen are stable while valid is high.

## Configuration
- Macro: YSYX_24100013_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to FETCH_REQ/MEM_REQ.
  - It counts every cycle in FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT.
  - On reaching TIMEOUT_CYCLES without handshake completion: HALT, halt_code=3.
- Without the macro: no counter; waits are unbounded; halt_code 3 never produced.

## Structure
- Package ysyx_24100013_pkg holds:
  - state enum.
  - itype codes (ITYPE_NONE..ITYPE_J).
  - RV32I opcode constants.
  - EBREAK encoding.
  - halt codes.
- Combinational sub-module ysyx_24100013_opdec maps opcode → itype, is_load, is_store, writes_rd, illegal.
- The FSM, inst latch and timeout counter stay in ysyx_24100013_seq.

## Test plan
- ADDI x1,x0,5 (32'h00500093), ready and response 1 cycle after request → itype=1.
  - rf_we and pc_we high in cycle 5 only.
- SW x1,0(x2) (32'h00112023), lsu_req_ready delayed 3 cycles → lsu_req_wen=1, held valid 3 cycles.
  - itype=2; rf_we=0, pc_we=1 at WB.
- ADDI x0,x0,0 (32'h00000013) → rf_we=0, pc_we=1.
- ebreak (32'h00100073) → halt=1, halt_code=1, no pc_we; further ifu_rsp_valid ignored.
- Opcode 7'b1111111 → halt_code=2.
  - With timeout defined, TIMEOUT_CYCLES=8 and ifu_rsp_valid never asserted → halt_code=3 after 8 cycles.
- rst pulsed during MEM_WAIT of an LW → next cycle FETCH_REQ.
  - All outputs at reset values; late lsu_rsp_valid ignored.
